// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants, memory depth and pipeline-register records for the MEM stage
package mips_pkg;

    localparam int DEPTH_DEF  = 512;
    localparam int ADDR_W_DEF = 9;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [5:0]  opcode;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic        misalign;
    } mem_wb_t;

    function automatic logic is_word_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_byte_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX-to-MEM inputs and M/W-stage outputs of the MEM stage
interface mem_stage_if;

    logic        RegWrite_in;
    logic        MemtoReg_in;
    logic        MemWrite_in;
    logic [5:0]  Opcode_in;
    logic [31:0] ALU_result_in;
    logic [31:0] WriteData_in;
    logic [4:0]  WriteReg_in;

    logic        RegWrite_M;
    logic [4:0]  WriteReg_M;
    logic [31:0] ALU_result_M;
    logic        RegWrite_W;
    logic [4:0]  WriteReg_W;
    logic [31:0] Result_W;
    logic [31:0] ReadData_W;
    logic        Misalign_W;

    modport master (
        output RegWrite_in, MemtoReg_in, MemWrite_in, Opcode_in,
               ALU_result_in, WriteData_in, WriteReg_in,
        input  RegWrite_M, WriteReg_M, ALU_result_M, RegWrite_W,
               WriteReg_W, Result_W, ReadData_W, Misalign_W
    );

    modport slave (
        input  RegWrite_in, MemtoReg_in, MemWrite_in, Opcode_in,
               ALU_result_in, WriteData_in, WriteReg_in,
        output RegWrite_M, WriteReg_M, ALU_result_M, RegWrite_W,
               WriteReg_W, Result_W, ReadData_W, Misalign_W
    );

endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word data memory, synchronous write / asynchronous read; byte lanes under MEM_SUBWORD_EN
module data_mem #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
`ifdef MEM_SUBWORD_EN
    input  logic [3:0]        be,
`endif
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

`ifdef MEM_SUBWORD_EN
    // Unselected lanes keep their old contents, giving read-modify-write in one edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end
`endif

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX_MEM register, data memory, MEM_WB register (MEM_SUBWORD_EN adds lb/lbu/sb)
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Stall,
    input  logic        Flush,
    mem_stage_if.slave  bus
);

    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic              wb_advance;
    logic [ADDR_W-1:0] mem_idx;
    logic [1:0]        byte_off;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    // A flush bubbles EX_MEM but must still let the instruction in M retire.
    assign wb_advance = !Stall || Flush;
    assign mem_idx    = ex_mem_q.alu_result[ADDR_W+1:2];
    assign byte_off   = ex_mem_q.alu_result[1:0];

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (Flush) begin
            ex_mem_d = '0;
        end else if (!Stall) begin
            ex_mem_d.reg_write  = bus.RegWrite_in && (bus.WriteReg_in != 5'd0);
            ex_mem_d.mem_to_reg = bus.MemtoReg_in;
            ex_mem_d.mem_write  = bus.MemWrite_in;
            ex_mem_d.opcode     = bus.Opcode_in;
            ex_mem_d.alu_result = bus.ALU_result_in;
            ex_mem_d.write_data = bus.WriteData_in;
            ex_mem_d.write_reg  = bus.WriteReg_in;
        end
    end

`ifdef MEM_SUBWORD_EN
    logic [3:0] mem_be;
    logic [7:0] rd_byte;

    always_comb begin
        case (byte_off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        load_data = rd_word;
        if (ex_mem_q.opcode == OP_LB) begin
            load_data = {{24{rd_byte[7]}}, rd_byte};
        end else if (ex_mem_q.opcode == OP_LBU) begin
            load_data = {24'd0, rd_byte};
        end
    end

    always_comb begin
        mem_we    = ex_mem_q.mem_write && wb_advance && !RESET;
        mem_be    = 4'hF;
        mem_wdata = ex_mem_q.write_data;
        if (ex_mem_q.opcode == OP_SB) begin
            mem_be    = 4'b0001 << byte_off;
            mem_wdata = {4{ex_mem_q.write_data[7:0]}};
        end
    end
`else
    assign load_data = is_byte_op(ex_mem_q.opcode) ? 32'd0 : rd_word;
    assign mem_we    = ex_mem_q.mem_write && wb_advance && !RESET
                       && !is_byte_op(ex_mem_q.opcode);
    assign mem_wdata = ex_mem_q.write_data;
`endif

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (CLOCK),
        .we    (mem_we),
`ifdef MEM_SUBWORD_EN
        .be    (mem_be),
`endif
        .addr  (mem_idx),
        .wdata (mem_wdata),
        .rdata (rd_word)
    );

    always_comb begin
        mem_wb_d = mem_wb_q;
        if (wb_advance) begin
            mem_wb_d.reg_write  = ex_mem_q.reg_write;
            mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
            mem_wb_d.write_reg  = ex_mem_q.write_reg;
            mem_wb_d.alu_result = ex_mem_q.alu_result;
            mem_wb_d.read_data  = load_data;
            mem_wb_d.misalign   = is_word_op(ex_mem_q.opcode) && (byte_off != 2'd0);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.RegWrite_M   = ex_mem_q.reg_write;
    assign bus.WriteReg_M   = ex_mem_q.write_reg;
    assign bus.ALU_result_M = ex_mem_q.alu_result;
    assign bus.RegWrite_W   = mem_wb_q.reg_write;
    assign bus.WriteReg_W   = mem_wb_q.write_reg;
    assign bus.ReadData_W   = mem_wb_q.read_data;
    assign bus.Misalign_W   = mem_wb_q.misalign;
    assign bus.Result_W     = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_result;

endmodule
